// File: rtl/ad9833_spi_drv.sv
// rtl/ad9833_spi_drv.sv - AD9833 16-bit serial word driver (FSYNC/SCLK/SDATA)
// Optional sticky spi_err_o for starts while busy: define AD9833_SPI_ERR_EN.
module ad9833_spi_drv #(
  parameter int SCLK_DIV    = 5,
  parameter int FSYNC_SETUP = 2,
  parameter int FSYNC_HOLD  = 2,
  parameter int GAP_CYC     = 4
) (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  input  logic        start_pluse_i,
  input  logic [15:0] ad9833_cfg_data_i,
  output logic        ad9833_bus_busy_o,
  output logic        ad9833_fsync_o,
  output logic        ad9833_sclk_o,
  output logic        ad9833_sdata_o
`ifdef AD9833_SPI_ERR_EN
  , output logic      spi_err_o
`endif
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST   = 8'(SCLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(FSYNC_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(FSYNC_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);

  state_t      state_q, state_nxt;
  logic [7:0]  phase_q, phase_nxt;
  logic [3:0]  bit_q, bit_nxt;
  logic [15:0] shreg_q, shreg_nxt;
  logic        busy_q, busy_nxt;
  logic        fsync_q, fsync_nxt;
  logic        sclk_q, sclk_nxt;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      phase_q <= 8'd0;
      bit_q   <= 4'd0;
      shreg_q <= 16'd0;
      busy_q  <= 1'b0;
      fsync_q <= 1'b1;
      sclk_q  <= 1'b1;
    end else begin
      state_q <= state_nxt;
      phase_q <= phase_nxt;
      bit_q   <= bit_nxt;
      shreg_q <= shreg_nxt;
      busy_q  <= busy_nxt;
      fsync_q <= fsync_nxt;
      sclk_q  <= sclk_nxt;
    end
  end

  // The phase counter times one SCLK half-period; the registered sclk level
  // tells which half we are in, so 8 bits cover SCLK_DIV up to 255.
  always_comb begin
    state_nxt = state_q;
    phase_nxt = phase_q;
    bit_nxt   = bit_q;
    shreg_nxt = shreg_q;
    busy_nxt  = busy_q;
    fsync_nxt = fsync_q;
    sclk_nxt  = sclk_q;
    case (state_q)
      IDLE: begin
        if (start_pluse_i) begin
          shreg_nxt = ad9833_cfg_data_i;
          busy_nxt  = 1'b1;
          fsync_nxt = 1'b0;
          sclk_nxt  = 1'b1;
          phase_nxt = 8'd0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (phase_q == SETUP_LAST) begin
          phase_nxt = 8'd0;
          bit_nxt   = 4'd15;
          state_nxt = SHIFT;
        end else begin
          phase_nxt = phase_q + 8'd1;
        end
      end
      SHIFT: begin
        if (phase_q != DIV_LAST) begin
          phase_nxt = phase_q + 8'd1;
        end else begin
          phase_nxt = 8'd0;
          if (sclk_q) begin
            sclk_nxt = 1'b0;
          end else begin
            // Rising edge: next bit appears together with sclk going high.
            sclk_nxt  = 1'b1;
            shreg_nxt = {shreg_q[14:0], 1'b0};
            if (bit_q == 4'd0) state_nxt = HOLD;
            else               bit_nxt   = bit_q - 4'd1;
          end
        end
      end
      HOLD: begin
        if (phase_q == HOLD_LAST) begin
          phase_nxt = 8'd0;
          fsync_nxt = 1'b1;
          state_nxt = GAP;
        end else begin
          phase_nxt = phase_q + 8'd1;
        end
      end
      GAP: begin
        if (phase_q == GAP_LAST) begin
          phase_nxt = 8'd0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          phase_nxt = phase_q + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ad9833_bus_busy_o = busy_q;
  assign ad9833_fsync_o    = fsync_q;
  assign ad9833_sclk_o     = sclk_q;
  assign ad9833_sdata_o    = shreg_q[15];

`ifdef AD9833_SPI_ERR_EN
  logic err_q;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i)                                err_q <= 1'b0;
    else if (start_pluse_i && state_q != IDLE) err_q <= 1'b1;
  end

  assign spi_err_o = err_q;
`endif

endmodule

// File: tb/tb_ad9833_spi_drv.sv
// tb/tb_ad9833_spi_drv.sv - directed bench for ad9833_spi_drv
// Covers default and minimum-timing instances; define AD9833_SPI_ERR_EN for the error flag.
module tb_ad9833_spi_drv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data = 16'h0;
  logic        sel = 1'b0;

  logic busy_d, fsync_d, sclk_d, sdata_d;
  logic busy_f, fsync_f, sclk_f, sdata_f;
  logic m_busy, m_fsync, m_sclk, m_sdata;
`ifdef AD9833_SPI_ERR_EN
  logic err_d, err_f;
`endif

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ad9833_spi_drv dut (
    .sys_clk_i(clk), .rst_i(rst), .start_pluse_i(start & ~sel),
    .ad9833_cfg_data_i(data), .ad9833_bus_busy_o(busy_d),
    .ad9833_fsync_o(fsync_d), .ad9833_sclk_o(sclk_d), .ad9833_sdata_o(sdata_d)
`ifdef AD9833_SPI_ERR_EN
    , .spi_err_o(err_d)
`endif
  );

  ad9833_spi_drv #(.SCLK_DIV(1), .FSYNC_SETUP(1), .FSYNC_HOLD(1), .GAP_CYC(1)) dut_f (
    .sys_clk_i(clk), .rst_i(rst), .start_pluse_i(start & sel),
    .ad9833_cfg_data_i(data), .ad9833_bus_busy_o(busy_f),
    .ad9833_fsync_o(fsync_f), .ad9833_sclk_o(sclk_f), .ad9833_sdata_o(sdata_f)
`ifdef AD9833_SPI_ERR_EN
    , .spi_err_o(err_f)
`endif
  );

  assign m_busy  = sel ? busy_f  : busy_d;
  assign m_fsync = sel ? fsync_f : fsync_d;
  assign m_sclk  = sel ? sclk_f  : sclk_d;
  assign m_sdata = sel ? sdata_f : sdata_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge with busy=0 (or after reset).
  task automatic xfer(input string tag, input logic [15:0] w, input int exp_busy,
                      input int exp_flo, input int exp_gap, input int inj_a,
                      input int inj_b, input int rst_fall);
    int busy_n, flo, fhi_tail, falls, guard;
    logic [15:0] rx;
    logic psclk;
    busy_n = 0; flo = 0; fhi_tail = 0; falls = 0; guard = 0;
    rx = 16'h0; psclk = 1'b1;
    data = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0; data = 16'h0;
    check({tag, "_first_busy"},  {31'd0, m_busy},  32'd1);
    check({tag, "_first_fsync"}, {31'd0, m_fsync}, 32'd0);
    check({tag, "_first_sdata"}, {31'd0, m_sdata}, {31'd0, w[15]});
    while (m_busy && guard < 2000) begin
      if (busy_n == inj_a || busy_n == inj_b) begin
        start = 1'b1; data = 16'h1234;
      end else begin
        start = 1'b0;
      end
      busy_n++;
      if (!m_fsync) begin flo++; fhi_tail = 0; end
      else fhi_tail++;
      if (psclk && !m_sclk) begin
        rx = {rx[14:0], m_sdata};
        falls++;
      end
      psclk = m_sclk;
      if (rst_fall > 0 && falls == rst_fall) begin
        start = 1'b0;
        rst = 1'b1;
        #1;
        check({tag, "_rst_fsync"}, {31'd0, m_fsync}, 32'd1);
        check({tag, "_rst_sclk"},  {31'd0, m_sclk},  32'd1);
        check({tag, "_rst_busy"},  {31'd0, m_busy},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check({tag, "_timeout"}, {31'd0, guard < 2000}, 32'd1);
    check({tag, "_data"},    {16'd0, rx},           {16'd0, w});
    check({tag, "_falls"},   falls,                 32'd16);
    check({tag, "_busy"},    busy_n,                exp_busy);
    check({tag, "_fsync_lo"}, flo,                  exp_flo);
    check({tag, "_gap"},     fhi_tail,              exp_gap);
    check({tag, "_idle_fsync"}, {31'd0, m_fsync},   32'd1);
    check({tag, "_idle_sdata"}, {31'd0, m_sdata},   32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy",  {31'd0, m_busy},  32'd0);
    check("rst_fsync", {31'd0, m_fsync}, 32'd1);
    check("rst_sclk",  {31'd0, m_sclk},  32'd1);
    check("rst_sdata", {31'd0, m_sdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    xfer("w2000", 16'h2000, 168, 164, 4, -1, -1, 0);
    xfer("w7ddc", 16'h7DDC, 168, 164, 4, -1, -1, 0);
    xfer("w4001", 16'h4001, 168, 164, 4, -1, -1, 0);
`ifdef AD9833_SPI_ERR_EN
    check("err_clear", {31'd0, err_d}, 32'd0);
`endif
    xfer("wffff", 16'hFFFF, 168, 164, 4, 10, 50, 0);
`ifdef AD9833_SPI_ERR_EN
    check("err_set", {31'd0, err_d}, 32'd1);
`endif
    repeat (3) @(negedge clk);
    check("no_extra_word", {31'd0, m_busy}, 32'd0);

    xfer("w5a5a_rst", 16'h5A5A, 168, 164, 4, -1, -1, 7);
    repeat (5) @(negedge clk);
    check("post_rst_busy",  {31'd0, m_busy},  32'd0);
    check("post_rst_fsync", {31'd0, m_fsync}, 32'd1);
    check("post_rst_sclk",  {31'd0, m_sclk},  32'd1);
`ifdef AD9833_SPI_ERR_EN
    check("post_rst_err", {31'd0, err_d}, 32'd0);
`endif
    xfer("w0001", 16'h0001, 168, 164, 4, -1, -1, 0);

    sel = 1'b1;
    @(negedge clk);
    xfer("fast_a5a5", 16'hA5A5, 35, 34, 1, -1, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
